// File: rtl/spfp_int_to_float.sv
// ----------------------------------------------------------------------------
// spfp_int_to_float
//
// Purpose:
//   Converts a 32-bit signed or unsigned integer into an IEEE-754
//   single-precision value. It uses a multi-cycle normalise loop:
//   the magnitude shifts left by one bit per cycle until its MSB is set.
//   A single rounding cycle follows, and the result is then held until
//   the consumer takes it.
//
// Configuration:
//   SPFP_I2F_ROUND_EN  defined   -> round-to-nearest-even on the 8 dropped bits
//                      undefined -> truncation of the 8 dropped bits
//   Latency and state sequence are identical in both builds.
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  synchronous active-high reset
//   a          in  32  integer operand, captured on the input handshake
//   is_signed  in   1  1: a is two's complement, 0: a is unsigned
//   in_valid   in   1  operand offered
//   in_ready   out  1  block can accept an operand (IDLE only)
//   z          out 32  single-precision result {sign, exp[7:0], frac[22:0]}
//   out_valid  out  1  z holds a result (DONE only)
//   out_ready  in   1  consumer accepts z
//   busy       out  1  state is not IDLE
// ----------------------------------------------------------------------------
module spfp_int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        is_signed,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent of a value whose MSB sits at bit 31: 127 + 31.
    localparam logic [7:0] EXP_TOP = 8'd158;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic [31:0] r_z;

    // ------------------------------------------------------------------
    // Operand capture: the two's complement negate of 0x80000000 wraps
    // back to 0x80000000, which is the correct magnitude 2^31.
    // ------------------------------------------------------------------
    logic        w_sign_in;
    logic [31:0] w_mag_in;

    assign w_sign_in = is_signed & a[31];
    assign w_mag_in  = w_sign_in ? (~a + 32'd1) : a;

    // ------------------------------------------------------------------
    // Rounding of the 8 bits that fall below the 23-bit fraction.
    // ------------------------------------------------------------------
    logic        w_round_up;
    logic [23:0] w_frac_sum;
    logic        w_carry;
    logic [22:0] w_frac_rnd;
    logic [7:0]  w_exp_rnd;

`ifdef SPFP_I2F_ROUND_EN
    // guard = mag[7], sticky = |mag[6:0], lsb = mag[8]; ties go to even.
    assign w_round_up = r_mag[7] & ((|r_mag[6:0]) | r_mag[8]);
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = &{1'b0, r_mag[7:0]};
    assign w_round_up        = 1'b0;
`endif

    assign w_frac_sum = {1'b0, r_mag[30:8]} + {23'd0, w_round_up};
    assign w_carry    = w_frac_sum[23];
    // On carry-out the fraction wraps to zero and the exponent absorbs it.
    assign w_frac_rnd = w_frac_sum[22:0];
    assign w_exp_rnd  = r_exp + {7'd0, w_carry};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (w_mag_in == 32'd0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (r_mag[31]) begin
                    w_state_next = ROUND;
                end
            end
            ROUND: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag  <= 32'd0;
            r_exp  <= 8'd0;
            r_sign <= 1'b0;
            r_z    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_mag_in;
                        r_exp  <= EXP_TOP;
                        // A zero operand skips straight to DONE as +0.
                        if (w_mag_in == 32'd0) begin
                            r_z <= 32'd0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ROUND: begin
                    r_z <= {r_sign, w_exp_rnd, w_frac_rnd};
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the state register only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign z         = r_z;

endmodule

// File: tb/tb_spfp_int_to_float.sv
// ----------------------------------------------------------------------------
// tb_spfp_int_to_float
//
// Directed self-checking bench for spfp_int_to_float. Expected results are
// hand-computed IEEE-754 encodings. Latency is counted in rising edges,
// including the accept edge: a zero operand gives 1, and a nonzero operand
// gives LZ+3 (the accept edge plus LZ+2 further edges).
// ----------------------------------------------------------------------------
module tb_spfp_int_to_float;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        is_signed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] z;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;

    spfp_int_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .is_signed (is_signed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Offer one operand, wait for the result, check value and latency,
    // then complete the output handshake.
    task automatic run_op(input string tag, input logic [31:0] av, input logic sv,
                          input logic [31:0] ez, input int elat);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        a         = av;
        is_signed = sv;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = $urandom;   // operand must only matter on the handshake
        is_signed = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk32({tag, "_lat"}, lat, elat);
        chk32({tag, "_z"}, z, ez);
        chk1({tag, "_in_ready_done"}, in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk1({tag, "_ov_after"}, out_valid, 1'b0);
        chk1({tag, "_busy_after"}, busy, 1'b0);
        $display("op %s: a=%h signed=%b z=%h latency=%0d", tag, av, sv, z, lat);
    endtask

    logic [31:0] exp_7fff;
    logic [31:0] exp_ffff_u;
    logic [31:0] exp_1234;

    initial begin
`ifdef SPFP_I2F_ROUND_EN
        exp_7fff   = 32'h4F000000;
        exp_ffff_u = 32'h4F800000;
        exp_1234   = 32'h4D91A2B4;
`else
        exp_7fff   = 32'h4EFFFFFF;
        exp_ffff_u = 32'h4F7FFFFF;
        exp_1234   = 32'h4D91A2B3;
`endif
        rst       = 1'b1;
        a         = 32'd0;
        is_signed = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk32("rst_z", z, 32'h0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed conversions
        run_op("one_s",      32'h00000001, 1'b1, 32'h3F800000, 34);
        run_op("min_s",      32'h80000000, 1'b1, 32'hCF000000, 3);
        run_op("min_u",      32'h80000000, 1'b0, 32'h4F000000, 3);
        run_op("neg1_s",     32'hFFFFFFFF, 1'b1, 32'hBF800000, 34);
        run_op("max_s",      32'h7FFFFFFF, 1'b1, exp_7fff, 4);
        run_op("tie_even_u", 32'h01000001, 1'b0, 32'h4B800000, 10);
        run_op("max_u",      32'hFFFFFFFF, 1'b0, exp_ffff_u, 3);
        run_op("zero",       32'h00000000, 1'b1, 32'h00000000, 1);
        run_op("neg3_s",     32'hFFFFFFFD, 1'b1, 32'hC0400000, 33);
        run_op("five_u",     32'h00000005, 1'b0, 32'h40A00000, 32);
        run_op("mixed_u",    32'h12345678, 1'b0, exp_1234, 6);

        // Hold DONE for 5 cycles with in_valid pulses that must be ignored
        @(negedge clk);
        a         = 32'h00000003;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!out_valid && guard < 60) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        chk1("hold_reached_done", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a        = 32'h00000001;
            @(posedge clk);
            #1;
            chk32("hold_z", z, 32'h40400000);
            chk1("hold_out_valid", out_valid, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
            $display("hold cycle %0d: z=%h out_valid=%b in_ready=%b", i, z, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk1("hold_release_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("hold_no_spurious_op", busy, 1'b0);

        // Reset on the 10th NORM cycle of a=1; rst beats in_valid/out_ready
        @(negedge clk);
        a         = 32'h00000001;
        is_signed = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk1("mid_norm_busy", busy, 1'b1);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk32("midrst_z", z, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk1("midrst_discarded", out_valid, 1'b0);
        $display("mid-NORM reset: z=%h out_valid=%b busy=%b", z, out_valid, busy);
        run_op("three_after_rst", 32'h00000003, 1'b0, 32'h40400000, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
